// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state, digit limits and BCD count types for the stopwatch core
package stopwatch_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] DIG_MAX_ONES = 4'd9;
  localparam logic [BCD_W-1:0] DIG_MAX_TENS = 4'd5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    LAP
  } state_t;

  typedef struct packed {
    logic [BCD_W-1:0] m_tens;
    logic [BCD_W-1:0] m_ones;
    logic [BCD_W-1:0] s_tens;
    logic [BCD_W-1:0] s_ones;
    logic [BCD_W-1:0] cs_tens;
    logic [BCD_W-1:0] cs_ones;
  } bcd_count_t;

  localparam bcd_count_t ZERO_COUNT = '0;

  // Anything at or above the limit folds back to zero, so a digit can never leave BCD range.
  function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] digit,
                                                input logic [BCD_W-1:0] max_val);
    bcd_step = (digit >= max_val) ? '0 : digit + 1'b1;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - one BCD digit of the count chain, wraps at MAX_VAL and carries out
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX_VAL = DIG_MAX_ONES
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] digit_d,
  output logic             carry
);

  logic [BCD_W-1:0] digit_q;

  // digit_d is exported so the parent can register the display in the same edge as the count.
  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (inc) begin
      digit_d = bcd_step(digit_q, MAX_VAL);
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign carry = inc & ~clr & (digit_q >= MAX_VAL);

endmodule

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - stopwatch timing core: clk_in tick extraction, control FSM, BCD count
// Optional lap feature: define STOPWATCH_LAP_EN to build the LAP state, lap register and lap_active.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       clk_in,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] cs_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] s_ones,
  output logic [3:0] s_tens,
  output logic [3:0] m_ones,
  output logic [3:0] m_tens,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic       prev_q;
  logic       ss_btn_q, clr_btn_q;
  state_t     state_q, state_d;
  bcd_count_t disp_q, disp_d;
  logic       running_q, running_d;
  logic       lap_active_q, lap_active_d;
  logic       overflow_q, overflow_d;

  bcd_count_t live, nxt;
  logic       tick, ss_press, clr_press, count_en;
  logic       c_cs1, c_cs10, c_s1, c_s10, c_m1, c_m10;

`ifdef STOPWATCH_LAP_EN
  logic       lap_btn_q, lap_press;
  bcd_count_t lap_reg_q, lap_reg_d;
  assign lap_press = lap & ~lap_btn_q;
`else
  logic       lap_unused;
  assign lap_unused = lap;
`endif

  assign tick      = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign ss_press  = start_stop & ~ss_btn_q;
  assign clr_press = clear & ~clr_btn_q;
  // The state before this edge's transition decides whether the tick counts.
  assign count_en  = tick & ~clr_press & ((state_q == RUN) || (state_q == LAP));

  bcd_digit_counter #(.MAX_VAL(DIG_MAX_ONES)) u_cs_ones (
    .clock(clock), .rst(rst), .clr(clr_press), .inc(count_en),
    .digit(live.cs_ones), .digit_d(nxt.cs_ones), .carry(c_cs1)
  );
  bcd_digit_counter #(.MAX_VAL(DIG_MAX_ONES)) u_cs_tens (
    .clock(clock), .rst(rst), .clr(clr_press), .inc(c_cs1),
    .digit(live.cs_tens), .digit_d(nxt.cs_tens), .carry(c_cs10)
  );
  bcd_digit_counter #(.MAX_VAL(DIG_MAX_ONES)) u_s_ones (
    .clock(clock), .rst(rst), .clr(clr_press), .inc(c_cs10),
    .digit(live.s_ones), .digit_d(nxt.s_ones), .carry(c_s1)
  );
  bcd_digit_counter #(.MAX_VAL(DIG_MAX_TENS)) u_s_tens (
    .clock(clock), .rst(rst), .clr(clr_press), .inc(c_s1),
    .digit(live.s_tens), .digit_d(nxt.s_tens), .carry(c_s10)
  );
  bcd_digit_counter #(.MAX_VAL(DIG_MAX_ONES)) u_m_ones (
    .clock(clock), .rst(rst), .clr(clr_press), .inc(c_s10),
    .digit(live.m_ones), .digit_d(nxt.m_ones), .carry(c_m1)
  );
  bcd_digit_counter #(.MAX_VAL(DIG_MAX_TENS)) u_m_tens (
    .clock(clock), .rst(rst), .clr(clr_press), .inc(c_m1),
    .digit(live.m_tens), .digit_d(nxt.m_tens), .carry(c_m10)
  );

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], clk_in};
    state_d = state_q;
`ifdef STOPWATCH_LAP_EN
    lap_reg_d = lap_reg_q;
`endif
    if (clr_press) begin
      state_d = IDLE;
`ifdef STOPWATCH_LAP_EN
      lap_reg_d = ZERO_COUNT;
`endif
    end else if (ss_press) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = PAUSE;
      endcase
    end
`ifdef STOPWATCH_LAP_EN
    else if (lap_press) begin
      // Latch the pre-increment value even when a tick lands on this edge.
      if (state_q == RUN) begin
        state_d   = LAP;
        lap_reg_d = live;
      end else if (state_q == LAP) begin
        state_d = RUN;
      end
    end
`endif

    running_d  = (state_d == RUN) || (state_d == LAP);
    overflow_d = c_m10;
`ifdef STOPWATCH_LAP_EN
    lap_active_d = (state_d == LAP);
    disp_d       = (state_d == LAP) ? lap_reg_d : nxt;
`else
    lap_active_d = 1'b0;
    disp_d       = nxt;
`endif
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      sync_q       <= '0;
      prev_q       <= 1'b0;
      ss_btn_q     <= 1'b0;
      clr_btn_q    <= 1'b0;
      state_q      <= IDLE;
      disp_q       <= ZERO_COUNT;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_btn_q    <= 1'b0;
      lap_reg_q    <= ZERO_COUNT;
`endif
    end else begin
      sync_q       <= sync_d;
      prev_q       <= sync_q[SYNC_STAGES-1];
      ss_btn_q     <= start_stop;
      clr_btn_q    <= clear;
      state_q      <= state_d;
      disp_q       <= disp_d;
      running_q    <= running_d;
      lap_active_q <= lap_active_d;
      overflow_q   <= overflow_d;
`ifdef STOPWATCH_LAP_EN
      lap_btn_q    <= lap;
      lap_reg_q    <= lap_reg_d;
`endif
    end
  end

  assign cs_ones    = disp_q.cs_ones;
  assign cs_tens    = disp_q.cs_tens;
  assign s_ones     = disp_q.s_ones;
  assign s_tens     = disp_q.s_tens;
  assign m_ones     = disp_q.m_ones;
  assign m_tens     = disp_q.m_tens;
  assign running    = running_q;
  assign lap_active = lap_active_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - scoreboard bench for stopwatch_core (lap checks follow STOPWATCH_LAP_EN)
module tb_stopwatch_core;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       clk_in = 1'b0;
  logic       start_stop = 1'b0;
  logic       lap = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens;
  logic       running, lap_active, overflow;

  stopwatch_core #(.SYNC_STAGES(2)) dut (
    .clock(clock), .rst(rst), .clk_in(clk_in),
    .start_stop(start_stop), .lap(lap), .clear(clear),
    .cs_ones(cs_ones), .cs_tens(cs_tens), .s_ones(s_ones), .s_tens(s_tens),
    .m_ones(m_ones), .m_tens(m_tens),
    .running(running), .lap_active(lap_active), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [23:0] digits;
    logic        run;
    logic        lapa;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_run = 0;
  int          n_fail = 0;
  int          model_t = 0;
  logic [23:0] obs_digits;

  assign obs_digits = {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones};

  // Total hundredths -> mm:ss.cc digits, wrapping at one hour.
  function automatic logic [23:0] to_bcd(input int t);
    int cs, s, m;
    cs = t % 100;
    s  = (t / 100) % 60;
    m  = (t / 6000) % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  task automatic push_exp(input logic [23:0] d, input logic r, input logic la);
    exp_t x;
    x.digits = d;
    x.run    = r;
    x.lapa   = la;
    sb.push_back(x);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_ticks(input int n, input bit counts);
    for (int i = 0; i < n; i++) begin
      clk_in = 1'b1;
      cyc(3);
      clk_in = 1'b0;
      cyc(3);
    end
    if (counts) model_t = (model_t + n) % 360000;
  endtask

  task automatic buttons(input logic ss, input logic lp, input logic cl);
    start_stop = ss;
    lap        = lp;
    clear      = cl;
    cyc(1);
    start_stop = 1'b0;
    lap        = 1'b0;
    clear      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    model_t = 0;
    push_exp(to_bcd(model_t), 1'b0, 1'b0);
    cyc(1);
    e = sb.pop_front();
    n_run++; if ({obs_digits, running, lap_active} !== {e.digits, e.run, e.lapa}) begin n_fail++;
      $display("FAIL reset: got %h/%b/%b want %h/%b/%b", obs_digits, running, lap_active, e.digits, e.run, e.lapa); end
    n_run++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_count();
    buttons(1'b1, 1'b0, 1'b0);
    push_exp(to_bcd(model_t), 1'b1, 1'b0);
    e = sb.pop_front();
    n_run++; if ({obs_digits, running, lap_active} !== {e.digits, e.run, e.lapa}) begin n_fail++;
      $display("FAIL start: got %h/%b/%b want %h/%b/%b", obs_digits, running, lap_active, e.digits, e.run, e.lapa); end
    clk_in = 1'b1;
    push_exp(to_bcd(model_t), 1'b1, 1'b0);
    cyc(2);
    e = sb.pop_front();
    n_run++; if (obs_digits !== e.digits) begin n_fail++;
      $display("FAIL latency_k1: got %h want %h", obs_digits, e.digits); end
    model_t = 1;
    push_exp(to_bcd(model_t), 1'b1, 1'b0);
    cyc(1);
    e = sb.pop_front();
    n_run++; if (obs_digits !== e.digits) begin n_fail++;
      $display("FAIL latency_k2: got %h want %h", obs_digits, e.digits); end
    clk_in = 1'b0;
    cyc(3);
    send_ticks(99, 1'b1);
    push_exp(to_bcd(model_t), 1'b1, 1'b0);
    e = sb.pop_front();
    n_run++; if ({obs_digits, running, lap_active} !== {e.digits, e.run, e.lapa}) begin n_fail++;
      $display("FAIL count_100: got %h/%b/%b want %h/%b/%b", obs_digits, running, lap_active, e.digits, e.run, e.lapa); end
    send_ticks(5899, 1'b1);
    push_exp(to_bcd(model_t), 1'b1, 1'b0);
    e = sb.pop_front();
    n_run++; if (obs_digits !== e.digits) begin n_fail++;
      $display("FAIL count_59_99: got %h want %h", obs_digits, e.digits); end
    send_ticks(1, 1'b1);
    push_exp(to_bcd(model_t), 1'b1, 1'b0);
    e = sb.pop_front();
    n_run++; if ({obs_digits, overflow} !== {e.digits, 1'b0}) begin n_fail++;
      $display("FAIL minute_carry: got %h/%b want %h/0", obs_digits, overflow, e.digits); end
  endtask

  task automatic test_wrap();
    force dut.u_m_tens.digit_d  = 4'd5;
    force dut.u_m_ones.digit_d  = 4'd9;
    force dut.u_s_tens.digit_d  = 4'd5;
    force dut.u_s_ones.digit_d  = 4'd9;
    force dut.u_cs_tens.digit_d = 4'd9;
    force dut.u_cs_ones.digit_d = 4'd9;
    cyc(1);
    release dut.u_m_tens.digit_d;
    release dut.u_m_ones.digit_d;
    release dut.u_s_tens.digit_d;
    release dut.u_s_ones.digit_d;
    release dut.u_cs_tens.digit_d;
    release dut.u_cs_ones.digit_d;
    model_t = 359999;
    push_exp(to_bcd(model_t), 1'b1, 1'b0);
    e = sb.pop_front();
    n_run++; if (obs_digits !== e.digits) begin n_fail++;
      $display("FAIL preload: got %h want %h", obs_digits, e.digits); end
    clk_in = 1'b1;
    cyc(2);
    n_run++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", overflow); end
    model_t = 0;
    push_exp(to_bcd(model_t), 1'b1, 1'b0);
    cyc(1);
    e = sb.pop_front();
    n_run++; if ({obs_digits, running, overflow} !== {e.digits, e.run, 1'b1}) begin n_fail++;
      $display("FAIL wrap: got %h/%b/%b want %h/%b/1", obs_digits, running, overflow, e.digits, e.run); end
    cyc(1);
    n_run++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle: got %b want 0", overflow); end
    clk_in = 1'b0;
    cyc(3);
  endtask

  task automatic test_lap();
    buttons(1'b0, 1'b0, 1'b1);
    model_t = 0;
    push_exp(to_bcd(model_t), 1'b0, 1'b0);
    e = sb.pop_front();
    n_run++; if ({obs_digits, running, lap_active} !== {e.digits, e.run, e.lapa}) begin n_fail++;
      $display("FAIL clear_idle: got %h/%b/%b want %h/%b/%b", obs_digits, running, lap_active, e.digits, e.run, e.lapa); end
    buttons(1'b1, 1'b0, 1'b0);
    send_ticks(500, 1'b1);
    buttons(1'b0, 1'b1, 1'b0);
`ifdef STOPWATCH_LAP_EN
    push_exp(to_bcd(500), 1'b1, 1'b1);
`else
    push_exp(to_bcd(500), 1'b1, 1'b0);
`endif
    e = sb.pop_front();
    n_run++; if ({obs_digits, running, lap_active} !== {e.digits, e.run, e.lapa}) begin n_fail++;
      $display("FAIL lap_enter: got %h/%b/%b want %h/%b/%b", obs_digits, running, lap_active, e.digits, e.run, e.lapa); end
    send_ticks(50, 1'b1);
`ifdef STOPWATCH_LAP_EN
    push_exp(to_bcd(500), 1'b1, 1'b1);
`else
    push_exp(to_bcd(model_t), 1'b1, 1'b0);
`endif
    e = sb.pop_front();
    n_run++; if ({obs_digits, running, lap_active} !== {e.digits, e.run, e.lapa}) begin n_fail++;
      $display("FAIL lap_frozen: got %h/%b/%b want %h/%b/%b", obs_digits, running, lap_active, e.digits, e.run, e.lapa); end
    buttons(1'b0, 1'b1, 1'b0);
    push_exp(to_bcd(model_t), 1'b1, 1'b0);
    e = sb.pop_front();
    n_run++; if ({obs_digits, running, lap_active} !== {e.digits, e.run, e.lapa}) begin n_fail++;
      $display("FAIL lap_exit: got %h/%b/%b want %h/%b/%b", obs_digits, running, lap_active, e.digits, e.run, e.lapa); end
  endtask

  task automatic test_stop_with_tick();
    buttons(1'b0, 1'b0, 1'b1);
    model_t = 0;
    buttons(1'b1, 1'b0, 1'b0);
    send_ticks(9, 1'b1);
    clk_in = 1'b1;
    cyc(2);
    start_stop = 1'b1;
    model_t = 10;
    push_exp(to_bcd(model_t), 1'b0, 1'b0);
    cyc(1);
    start_stop = 1'b0;
    e = sb.pop_front();
    n_run++; if ({obs_digits, running, lap_active} !== {e.digits, e.run, e.lapa}) begin n_fail++;
      $display("FAIL stop_tick: got %h/%b/%b want %h/%b/%b", obs_digits, running, lap_active, e.digits, e.run, e.lapa); end
    clk_in = 1'b0;
    cyc(3);
    send_ticks(20, 1'b0);
    push_exp(to_bcd(model_t), 1'b0, 1'b0);
    e = sb.pop_front();
    n_run++; if ({obs_digits, running} !== {e.digits, e.run}) begin n_fail++;
      $display("FAIL pause_hold: got %h/%b want %h/%b", obs_digits, running, e.digits, e.run); end
  endtask

  task automatic test_clear_priority();
    buttons(1'b1, 1'b0, 1'b0);
    send_ticks(1224, 1'b1);
    push_exp(to_bcd(model_t), 1'b1, 1'b0);
    e = sb.pop_front();
    n_run++; if ({obs_digits, running} !== {e.digits, e.run}) begin n_fail++;
      $display("FAIL pre_clear: got %h/%b want %h/%b", obs_digits, running, e.digits, e.run); end
    clk_in = 1'b1;
    cyc(2);
    start_stop = 1'b1;
    clear      = 1'b1;
    lap        = 1'b1;
    model_t = 0;
    push_exp(to_bcd(model_t), 1'b0, 1'b0);
    cyc(1);
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
    e = sb.pop_front();
    n_run++; if ({obs_digits, running, lap_active, overflow} !== {e.digits, e.run, e.lapa, 1'b0}) begin n_fail++;
      $display("FAIL clear_wins: got %h/%b/%b/%b want %h/%b/%b/0", obs_digits, running, lap_active, overflow, e.digits, e.run, e.lapa); end
    clk_in = 1'b0;
    cyc(3);
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    start_stop = 1'b1;
    cyc(1);
    for (int i = 0; i < 167; i++) begin
      clk_in = 1'b1;
      repeat (3) begin
        @(negedge clock);
        if (running !== 1'b1) bad++;
      end
      clk_in = 1'b0;
      repeat (3) begin
        @(negedge clock);
        if (running !== 1'b1) bad++;
      end
    end
    start_stop = 1'b0;
    model_t = 167;
    n_run++; if (bad !== 0) begin n_fail++; $display("FAIL hold_toggle: got %0d idle cycles want 0", bad); end
    push_exp(to_bcd(model_t), 1'b1, 1'b0);
    e = sb.pop_front();
    n_run++; if ({obs_digits, running} !== {e.digits, e.run}) begin n_fail++;
      $display("FAIL hold_count: got %h/%b want %h/%b", obs_digits, running, e.digits, e.run); end
  endtask

  task automatic test_reset_mid_run();
    send_ticks(10, 1'b1);
    clk_in = 1'b1;
    cyc(2);
    rst        = 1'b1;
    lap        = 1'b1;
    start_stop = 1'b1;
    model_t = 0;
    push_exp(to_bcd(model_t), 1'b0, 1'b0);
    cyc(1);
    e = sb.pop_front();
    n_run++; if ({obs_digits, running, lap_active, overflow} !== {e.digits, e.run, e.lapa, 1'b0}) begin n_fail++;
      $display("FAIL rst_mid: got %h/%b/%b/%b want %h/%b/%b/0", obs_digits, running, lap_active, overflow, e.digits, e.run, e.lapa); end
    rst        = 1'b0;
    lap        = 1'b0;
    start_stop = 1'b0;
    clk_in     = 1'b0;
    cyc(3);
    send_ticks(5, 1'b0);
    push_exp(to_bcd(model_t), 1'b0, 1'b0);
    e = sb.pop_front();
    n_run++; if ({obs_digits, running} !== {e.digits, e.run}) begin n_fail++;
      $display("FAIL post_rst_idle: got %h/%b want %h/%b", obs_digits, running, e.digits, e.run); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_lap();
    test_stop_with_tick();
    test_clear_priority();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
